// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   UART receive stage: synchronises the serial rx line and deserialises
//   8N1 frames (8E1 when UART_RX_PARITY_EN is defined). The four most
//   recent frames are kept in a shift buffer that drives the hex display.
//
// Optional feature macro: UART_RX_PARITY_EN (even-parity bit after data).
//
// Ports
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idles high
//   err_clr    clears frame_err / parity_err next cycle (a set wins)
//   RXBUF      [3:0][9:0] frame buffer, entry 0 newest, {stop,start,data}
//   rx_valid   one-cycle pulse alongside each new RXBUF[0]
//   frame_err  sticky, bad stop bit seen
//   parity_err sticky, parity mismatch seen (0 when parity disabled)
//   frame_cnt  frames held, saturates at 4
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             err_clr,
  output logic [3:0][9:0]  RXBUF,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic [2:0]       frame_cnt
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, COMMIT
  } state_t;

  state_t            state;
  logic [BW-1:0]     bcnt;
  logic [2:0]        idx;
  logic [7:0]        shreg;
  logic              stop_bit;

  // Metastability synchroniser; flops reset to the idle (high) level so a
  // reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;

  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      idx       <= '0;
      shreg     <= '0;
      stop_bit  <= 1'b0;
      RXBUF     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      // Clear first so that a stop-bit error in the same cycle overrides it.
      if (err_clr) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          // Sample the middle of the start bit; high here means a glitch.
          if (bcnt == HALF) begin
            bcnt  <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        DATA: begin
          // A full bit period after mid-start lands on mid-data.
          if (bcnt == LAST) begin
            bcnt       <= '0;
            shreg[idx] <= rxs;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        PARITY: begin
          if (bcnt == LAST) begin
            bcnt  <= '0;
            state <= STOP;
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        STOP: begin
          // Leaving at mid-stop gives half a bit of slack for the next start.
          if (bcnt == LAST) begin
            bcnt     <= '0;
            stop_bit <= rxs;
            if (!rxs) frame_err <= 1'b1;
            state    <= COMMIT;
          end else begin
            bcnt <= bcnt + ONE;
          end
        end
        COMMIT: begin
          RXBUF    <= {RXBUF[2:0], {stop_bit, 1'b0, shreg}};
          rx_valid <= 1'b1;
          if (frame_cnt != 3'd4) frame_cnt <= frame_cnt + 3'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data XOR parity must be 0. Set has priority over err_clr.
  always_ff @(posedge clk) begin
    if (rst)
      parity_err <= 1'b0;
    else if (state == PARITY && bcnt == LAST && ((^shreg) ^ rxs))
      parity_err <= 1'b1;
    else if (err_clr)
      parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
UART receive stage that deserialises the serial `rx` line into 10-bit frames. It holds the four most recent frames in a 4-entry shift buffer, `RXBUF`. `RXBUF` feeds the four-digit display controller directly, which shows `RXBUF[n][7:0]` as hex. The block sits between the board `rx` pin and the display/receive-side logic, mirroring the transmit side's `TXBUF`.

Parameters:
- `CLKS_PER_BIT`, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `SYNC_STAGES`, 2, flip-flops in the `rx` metastability synchroniser; must be ≥ 2.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line; idles high.
- `RXBUF` output [3:0][9:0]: frame buffer; entry 0 is newest; each entry is {stop, start, data[7:0]}.
- `rx_valid` output 1: one-cycle pulse when a frame is written to `RXBUF[0]`.
- `frame_err` output 1: sticky; set on bad stop bit; cleared by `rst` or `err_clr`.
- `parity_err` output 1: sticky parity mismatch flag (see Optional Feature).
- `err_clr` input 1: clears `frame_err` and `parity_err` the next cycle.
- `frame_cnt` output 3: frames held, saturating at 4.

Behaviour:
- Reset (synchronous, `rst`=1 at posedge): all outputs go to 0, FSM to IDLE, bit counters to 0, synchroniser flops to 1.
- Synchroniser: `rx` passes through `SYNC_STAGES` flip-flops; the FSM uses the synchronised value `rxs` only.
- Baud counter `bcnt` runs 0..`CLKS_PER_BIT`-1 and is reloaded on each state entry.
- FSM states: IDLE, START, DATA, (PARITY), STOP, COMMIT.
  - IDLE: wait for `rxs`=0, then go to START with `bcnt`=0.
  - START: at `bcnt`=`CLKS_PER_BIT`/2 (integer divide), sample `rxs`.
    - If 0: start is valid; reset `bcnt` and go to DATA with bit index 0.
    - If 1: glitch; return to IDLE with no other effect.
  - DATA: every `CLKS_PER_BIT` cycles (mid-bit), sample `rxs` into `shreg[idx]`, LSB first.
    - After idx 7, go to STOP (or PARITY if enabled).
  - STOP: at the mid-bit sample, latch the stop bit and go to COMMIT.
    - If the stop bit is 0, set `frame_err`; the frame is still committed.
  - COMMIT (1 cycle):
    - `RXBUF[3]`←`RXBUF[2]`, `RXBUF[2]`←`RXBUF[1]`, `RXBUF[1]`←`RXBUF[0]`.
    - `RXBUF[0]`←{stop, 1'b0, `shreg`}; bit 8 holds the sampled start level, always 0.
    - `rx_valid`=1 for this cycle.
    - `frame_cnt`←min(`frame_cnt`+1, 4).
    - Go to IDLE.
- Back-to-back frames: IDLE is entered about half a bit before the stop bit ends. A new falling edge immediately after the stop bit is caught without loss.
- Latency: COMMIT occurs `SYNC_STAGES` + 9.5×`CLKS_PER_BIT` + 1 cycles (±1) after the start-bit falling edge on `rx`.
- Buffer overflow: on a 5th frame the oldest (`RXBUF[3]`) is dropped silently; `frame_cnt` stays 4.
- `err_clr` and an error set in the same cycle: the set wins.
- `rst` mid-frame: the partial frame is discarded; `RXBUF` is cleared.
  - After reset the FSM waits in IDLE.
  - If `rx` is low when reset releases, the FSM enters START. It may glitch-reject or mis-frame the first frame; this is acceptable.
- `RXBUF` is registered and stable between COMMITs. The consumer may read it combinationally at any time.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit mid-bit.
  - If XOR(data, parity) ≠ 0, `parity_err` is set (sticky); the frame is still committed.
  - The frame is 11 bits on the wire; the stored layout is unchanged (parity not stored).
  - Latency grows by `CLKS_PER_BIT`.
- Undefined: no PARITY state; `parity_err` is tied to 0.

Test Plan (bench uses `CLKS_PER_BIT`=16):
1. Reset, `rx`=1 idle for 100 cycles → `RXBUF`=0, `frame_cnt`=0, `rx_valid` never asserted.
2. Send byte 0xA5 (stop=1) → one `rx_valid` pulse; `RXBUF[0]`=10'h2A5; `frame_cnt`=1; `frame_err`=0.
3. Send 0x12, 0x34, 0x56, 0x78, 0x9A back-to-back with no idle gap → 5 pulses.
   - Final `RXBUF[0..3]` = 10'h29A, 10'h278, 10'h256, 10'h234 (0x12 dropped).
   - `frame_cnt`=4.
4. Drive `rx` low for 4 cycles, then high → no `rx_valid`; FSM returns to IDLE; next byte 0x3C is received correctly as 10'h23C.
5. Send 0xFF with stop bit 0 → `RXBUF[0]`=10'h0FF, `frame_err`=1 (held).
   - Pulse `err_clr` → `frame_err`=0 next cycle.
6. Assert `rst` during data bit 4 of 0x55 → all outputs 0.
   - After reset, a full frame 0x55 → `RXBUF[0]`=10'h255, `frame_cnt`=1.
   - With `UART_RX_PARITY_EN`: 0x03 sent with parity 1 → `parity_err`=1.
